// File: rtl/rv_exit_monitor.sv
// Test-completion monitor: snoops hart writebacks/ecalls and latches a riscv-tests style exit result.
// Optional tohost store exit is enabled by defining RV_EXIT_MONITOR_TOHOST_EN.

module rv_exit_monitor_hart #(
  parameter logic [31:0] EXIT_ID = 32'h5d
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ecall,
  output logic        hit,
  output logic [31:0] a0_eff
);
  logic [31:0] a0_q, a7_q, a7_eff;
  logic        wb_a0, wb_a7;

  assign wb_a0 = wb_en && (wb_addr == 5'd10);
  assign wb_a7 = wb_en && (wb_addr == 5'd17);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0;
      a7_q <= '0;
    end else begin
      if (wb_a0) a0_q <= wb_data;
      if (wb_a7) a7_q <= wb_data;
    end
  end

  // Same-cycle writeback bypasses the shadow so "li a7,93; ecall" pairs exit with no bubble.
  assign a0_eff = wb_a0 ? wb_data : a0_q;
  assign a7_eff = wb_a7 ? wb_data : a7_q;
  assign hit    = ecall && (a7_eff == EXIT_ID);
endmodule

module rv_exit_monitor #(
  parameter int          NUM_HARTS      = 1,
  parameter logic [31:0] EXIT_ID        = 32'h5d,
  parameter int          CNT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NUM_HARTS-1:0]    wb_en_i,
  input  logic [5*NUM_HARTS-1:0]  wb_addr_i,
  input  logic [32*NUM_HARTS-1:0] wb_data_i,
  input  logic [NUM_HARTS-1:0]    ecall_i,
  input  logic [NUM_HARTS-1:0]    retire_i,
  input  logic                    st_en_i,
  input  logic [31:0]             st_addr_i,
  input  logic [31:0]             st_data_i,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    timeout_o,
  output logic [31:0]             exit_code_o,
  output logic [2:0]              exit_hart_o,
  output logic [CNT_W-1:0]        cycle_cnt_o,
  output logic [CNT_W-1:0]        instret_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] code;
    logic [2:0]  hart;
  } res_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                        state, state_nx;
  res_t                          res, res_nx;
  logic [CNT_W-1:0]              cyc, cyc_nx, ins, ins_nx;
  logic [CNT_W:0]                ins_sum;
  logic [3:0]                    pop;
  logic [NUM_HARTS-1:0]          hit;
  logic [NUM_HARTS-1:0][31:0]    a0_eff;
  logic                          ec_any;
  logic [2:0]                    ec_hart;
  logic [31:0]                   ec_a0;
  logic                          th_hit;
  logic                          to_hit;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    rv_exit_monitor_hart #(.EXIT_ID(EXIT_ID)) u_hart (
      .clk     (clk_i),
      .rst     (rst_i),
      .wb_en   (wb_en_i[h]),
      .wb_addr (wb_addr_i[5*h +: 5]),
      .wb_data (wb_data_i[32*h +: 32]),
      .ecall   (ecall_i[h]),
      .hit     (hit[h]),
      .a0_eff  (a0_eff[h])
    );
  end

`ifdef RV_EXIT_MONITOR_TOHOST_EN
  assign th_hit = st_en_i && (st_addr_i == TOHOST_ADDR) && st_data_i[0];
`else
  logic unused_tohost;
  assign unused_tohost = ^{st_en_i, st_addr_i, st_data_i, TOHOST_ADDR};
  assign th_hit        = 1'b0;
`endif

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cyc == TO_LAST);

  always_comb begin
    pop = '0;
    for (int h = 0; h < NUM_HARTS; h++) pop = pop + 4'(retire_i[h]);
  end

  // Descending scan so the lowest-indexed exiting hart is the one left standing.
  always_comb begin
    ec_any  = 1'b0;
    ec_hart = '0;
    ec_a0   = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (hit[h]) begin
        ec_any  = 1'b1;
        ec_hart = 3'(h);
        ec_a0   = a0_eff[h];
      end
    end
  end

  assign ins_sum = {1'b0, ins} + (CNT_W+1)'(pop);

  always_comb begin
    state_nx = state;
    res_nx   = res;
    cyc_nx   = cyc;
    ins_nx   = ins;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = RUN;
          cyc_nx   = '0;
          ins_nx   = '0;
        end
      end
      RUN: begin
        // The exit cycle itself is still counted before the counters freeze.
        cyc_nx = (&cyc) ? cyc : cyc + 1'b1;
        ins_nx = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
        if (ec_any) begin
          state_nx     = DONE;
          res_nx.done  = 1'b1;
          res_nx.pass  = (ec_a0 == 32'd0);
          res_nx.fail  = (ec_a0 != 32'd0);
          res_nx.code  = ec_a0 >> 1;
          res_nx.hart  = ec_hart;
        end else if (th_hit) begin
          state_nx     = DONE;
          res_nx.done  = 1'b1;
          res_nx.pass  = (st_data_i == 32'd1);
          res_nx.fail  = (st_data_i != 32'd1);
          res_nx.code  = st_data_i >> 1;
          res_nx.hart  = 3'd0;
        end else if (to_hit) begin
          state_nx       = DONE;
          res_nx.done    = 1'b1;
          res_nx.fail    = 1'b1;
          res_nx.timeout = 1'b1;
          res_nx.code    = 32'd0;
          res_nx.hart    = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      res   <= '0;
      cyc   <= '0;
      ins   <= '0;
    end else begin
      state <= state_nx;
      res   <= res_nx;
      cyc   <= cyc_nx;
      ins   <= ins_nx;
    end
  end

  assign done_o        = res.done;
  assign pass_o        = res.pass;
  assign fail_o        = res.fail;
  assign timeout_o     = res.timeout;
  assign exit_code_o   = res.code;
  assign exit_hart_o   = res.hart;
  assign cycle_cnt_o   = cyc;
  assign instret_cnt_o = ins;
endmodule

// File: tb/tb_rv_exit_monitor.sv
// Self-checking bench for rv_exit_monitor: directed scenarios plus randomized runs against a behavioural model.
module tb_rv_exit_monitor;
  localparam int          NH     = 2;
  localparam logic [31:0] EXIT   = 32'h5d;
  localparam int          CW     = 7;
  localparam int          TO     = 100;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          CMAX   = (1 << CW) - 1;
  localparam int          OW     = 4 + 32 + 3 + 2*CW;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [NH-1:0]    wb_en = '0, ecall = '0, retire = '0;
  logic [5*NH-1:0]  wb_addr = '0;
  logic [32*NH-1:0] wb_data = '0;
  logic             st_en = 1'b0;
  logic [31:0]      st_addr = '0, st_data = '0;
  logic             done_o, pass_o, fail_o, timeout_o;
  logic [31:0]      exit_code_o;
  logic [2:0]       exit_hart_o;
  logic [CW-1:0]    cycle_cnt_o, instret_cnt_o;
  logic [OW-1:0]    obs;

  int total = 0, bad = 0;

  // Model state: 0 idle, 1 running, 2 finished.
  int          m_st, m_cyc, m_ins;
  logic [31:0] m_a0 [NH];
  logic [31:0] m_a7 [NH];
  logic        m_done, m_pass, m_fail, m_to;
  logic [31:0] m_code;
  logic [2:0]  m_hart;

  rv_exit_monitor #(.NUM_HARTS(NH), .EXIT_ID(EXIT), .CNT_W(CW), .TIMEOUT_CYCLES(TO),
                    .TOHOST_ADDR(TOHOST)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .ecall_i(ecall), .retire_i(retire), .st_en_i(st_en),
    .st_addr_i(st_addr), .st_data_i(st_data), .done_o(done_o), .pass_o(pass_o),
    .fail_o(fail_o), .timeout_o(timeout_o), .exit_code_o(exit_code_o),
    .exit_hart_o(exit_hart_o), .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o));

  always #5 clk = ~clk;

  assign obs = {done_o, pass_o, fail_o, timeout_o, exit_code_o, exit_hart_o, cycle_cnt_o, instret_cnt_o};

  function automatic logic [OW-1:0] expv();
    return {m_done, m_pass, m_fail, m_to, m_code, m_hart, CW'(m_cyc), CW'(m_ins)};
  endfunction

  task automatic clear_inputs();
    start = 0; wb_en = '0; wb_addr = '0; wb_data = '0; ecall = '0; retire = '0;
    st_en = 0; st_addr = '0; st_data = '0;
  endtask

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_ins = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_code = '0; m_hart = '0;
    for (int h = 0; h < NH; h++) begin m_a0[h] = '0; m_a7[h] = '0; end
  endtask

  task automatic set_wb(input int h, input logic [4:0] rd, input logic [31:0] d);
    wb_en[h] = 1'b1;
    wb_addr[5*h +: 5] = rd;
    wb_data[32*h +: 32] = d;
  endtask

  // Advance the model by one clock from the driven inputs, then clock the DUT.
  task automatic tick();
    int hit, pc;
    logic [31:0] a0e, a7e, xa0;
    hit = -1; xa0 = '0;
    for (int h = NH - 1; h >= 0; h--) begin
      a0e = (wb_en[h] && wb_addr[5*h +: 5] == 5'd10) ? wb_data[32*h +: 32] : m_a0[h];
      a7e = (wb_en[h] && wb_addr[5*h +: 5] == 5'd17) ? wb_data[32*h +: 32] : m_a7[h];
      if (ecall[h] && a7e == EXIT) begin hit = h; xa0 = a0e; end
    end
    if (m_st == 1) begin
      pc = $countones(retire);
      m_ins = (m_ins + pc > CMAX) ? CMAX : m_ins + pc;
      if (hit >= 0) begin
        m_st = 2; m_done = 1; m_pass = (xa0 == 0); m_fail = (xa0 != 0);
        m_code = xa0 >> 1; m_hart = 3'(hit);
      end
`ifdef RV_EXIT_MONITOR_TOHOST_EN
      else if (st_en && st_addr == TOHOST && st_data[0]) begin
        m_st = 2; m_done = 1; m_pass = (st_data == 1); m_fail = (st_data != 1);
        m_code = st_data >> 1; m_hart = 3'd0;
      end
`endif
      else if (TO != 0 && m_cyc == TO - 1) begin
        m_st = 2; m_done = 1; m_fail = 1; m_to = 1; m_code = '0; m_hart = 3'd0;
      end
      m_cyc = (m_cyc == CMAX) ? CMAX : m_cyc + 1;
    end else if (m_st == 0 && start) begin
      m_st = 1; m_cyc = 0; m_ins = 0;
    end
    for (int h = 0; h < NH; h++) begin
      if (wb_en[h] && wb_addr[5*h +: 5] == 5'd10) m_a0[h] = wb_data[32*h +: 32];
      if (wb_en[h] && wb_addr[5*h +: 5] == 5'd17) m_a7[h] = wb_data[32*h +: 32];
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== '0) begin
      $display("FAIL reset_state got=%h want=0", obs); bad++;
    end
  endtask

  task automatic test_pass();
    do_reset();
    start = 1; tick();
    set_wb(0, 5'd10, 32'd0); retire = 2'b01; tick();
    set_wb(0, 5'd17, EXIT);  retire = 2'b01; tick();
    total++;
    if (done_o !== 1'b0) begin $display("FAIL pass_early_done got=%b want=0", done_o); bad++; end
    ecall = 2'b01; retire = 2'b01; tick();
    total++;
    if ({done_o, pass_o, fail_o, exit_code_o, exit_hart_o, cycle_cnt_o, instret_cnt_o} !==
        {1'b1, 1'b1, 1'b0, 32'd0, 3'd0, 7'd3, 7'd3}) begin
      $display("FAIL pass_exit got=%b%b%b code=%0d hart=%0d cyc=%0d ins=%0d want=110 code=0 hart=0 cyc=3 ins=3",
               done_o, pass_o, fail_o, exit_code_o, exit_hart_o, cycle_cnt_o, instret_cnt_o); bad++;
    end
    total++;
    if (obs !== expv()) begin $display("FAIL pass_model got=%h want=%h", obs, expv()); bad++; end
  endtask

  task automatic test_fail_code();
    do_reset();
    start = 1; tick();
    set_wb(0, 5'd10, 32'd6); tick();
    set_wb(0, 5'd17, EXIT);  tick();
    ecall = 2'b01; tick();
    total++;
    if ({done_o, pass_o, fail_o, exit_code_o} !== {1'b1, 1'b0, 1'b1, 32'd3}) begin
      $display("FAIL fail_code got=%b%b%b code=%0d want=101 code=3", done_o, pass_o, fail_o, exit_code_o); bad++;
    end
  endtask

  task automatic test_bypass();
    do_reset();
    start = 1; tick();
    set_wb(0, 5'd17, EXIT); ecall = 2'b01; tick();
    total++;
    if ({done_o, pass_o, exit_code_o} !== {1'b1, 1'b1, 32'd0}) begin
      $display("FAIL bypass_exit got=%b%b code=%0d want=11 code=0", done_o, pass_o, exit_code_o); bad++;
    end
    // Non-exit ecall (a7 != EXIT_ID) after a fresh start must be ignored.
    do_reset();
    set_wb(1, 5'd17, 32'd64); tick();
    start = 1; tick();
    ecall = 2'b10; tick();
    total++;
    if (done_o !== 1'b0) begin $display("FAIL non_exit_ecall got=%b want=0", done_o); bad++; end
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1; tick();
    repeat (TO - 1) begin retire = 2'b11; tick(); end
    total++;
    if ({done_o, cycle_cnt_o} !== {1'b0, 7'(TO - 1)}) begin
      $display("FAIL timeout_early got done=%b cyc=%0d want done=0 cyc=%0d", done_o, cycle_cnt_o, TO - 1); bad++;
    end
    retire = 2'b11; tick();
    total++;
    if ({done_o, pass_o, fail_o, timeout_o, exit_code_o, cycle_cnt_o, instret_cnt_o} !==
        {4'b1011, 32'd0, 7'(TO), 7'(CMAX)}) begin
      $display("FAIL timeout_fire got=%b%b%b%b code=%0d cyc=%0d ins=%0d want=1011 code=0 cyc=%0d ins=%0d",
               done_o, pass_o, fail_o, timeout_o, exit_code_o, cycle_cnt_o, instret_cnt_o, TO, CMAX); bad++;
    end
    set_wb(0, 5'd17, EXIT); ecall = 2'b01; retire = 2'b11; start = 1; tick();
    total++;
    if ({done_o, pass_o, fail_o, timeout_o, exit_code_o, cycle_cnt_o, instret_cnt_o} !==
        {4'b1011, 32'd0, 7'(TO), 7'(CMAX)}) begin
      $display("FAIL done_sticky got=%b%b%b%b cyc=%0d ins=%0d want=1011 cyc=%0d ins=%0d",
               done_o, pass_o, fail_o, timeout_o, cycle_cnt_o, instret_cnt_o, TO, CMAX); bad++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start = 1; tick();
    set_wb(0, 5'd10, 32'd4); set_wb(1, 5'd10, 32'd0); tick();
    set_wb(0, 5'd17, EXIT);  set_wb(1, 5'd17, EXIT);  tick();
    ecall = 2'b11; retire = 2'b11; tick();
    total++;
    if ({done_o, fail_o, exit_code_o, exit_hart_o, instret_cnt_o} !== {1'b1, 1'b1, 32'd2, 3'd0, 7'd2}) begin
      $display("FAIL simultaneous got done=%b fail=%b code=%0d hart=%0d ins=%0d want 1 1 2 0 2",
               done_o, fail_o, exit_code_o, exit_hart_o, instret_cnt_o); bad++;
    end
    // Only hart1 exits: reported hart must be 1.
    do_reset();
    start = 1; tick();
    set_wb(1, 5'd17, EXIT); set_wb(0, 5'd17, EXIT); ecall = 2'b10; tick();
    total++;
    if ({done_o, pass_o, exit_hart_o} !== {1'b1, 1'b1, 3'd1}) begin
      $display("FAIL hart1_exit got done=%b pass=%b hart=%0d want 1 1 1", done_o, pass_o, exit_hart_o); bad++;
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start = 1; tick();
    repeat (37) begin retire = 2'b01; tick(); end
    total++;
    if ({cycle_cnt_o, instret_cnt_o} !== {7'd37, 7'd37}) begin
      $display("FAIL mid_run_count got cyc=%0d ins=%0d want 37 37", cycle_cnt_o, instret_cnt_o); bad++;
    end
    rst = 1; model_reset(); #1;
    total++;
    if (obs !== '0) begin $display("FAIL mid_run_reset got=%h want=0", obs); bad++; end
    @(posedge clk); #1; rst = 0;
    start = 1; tick();
    st_en = 1; st_addr = TOHOST; st_data = 32'd1; tick();
    total++;
`ifdef RV_EXIT_MONITOR_TOHOST_EN
    if ({done_o, pass_o, fail_o, exit_code_o, exit_hart_o} !== {3'b110, 32'd0, 3'd0}) begin
      $display("FAIL tohost_pass got=%b%b%b code=%0d want=110 code=0", done_o, pass_o, fail_o, exit_code_o); bad++;
    end
`else
    if (done_o !== 1'b0) begin $display("FAIL tohost_ignored got=%b want=0", done_o); bad++; end
`endif
  endtask

  task automatic rand_inputs();
    logic [4:0]  rd;
    logic [31:0] d;
    for (int h = 0; h < NH; h++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: rd = 5'd10;  1: rd = 5'd17;  2: rd = 5'd0;  default: rd = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: d = 32'd0;  1: d = EXIT;  2: d = $urandom_range(0, 15);  default: d = $urandom;
        endcase
        set_wb(h, rd, d);
      end
      ecall[h]  = ($urandom_range(0, 15) == 0);
      retire[h] = 1'($urandom_range(0, 1));
    end
    start   = ($urandom_range(0, 20) == 0);
    st_en   = ($urandom_range(0, 30) == 0);
    st_addr = ($urandom_range(0, 1) == 0) ? TOHOST : $urandom;
    st_data = $urandom_range(0, 7);
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin rand_inputs(); start = 0; tick(); end
      start = 1; tick();
      for (int i = 0; i < 110; i++) begin
        rand_inputs();
        tick();
        total++;
        if (obs !== expv()) begin
          $display("FAIL random ep=%0d cyc=%0d got=%h want=%h", ep, i, obs, expv()); bad++;
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2;
    total++;
    if (obs !== '0) begin $display("FAIL reset_async got=%h want=0", obs); bad++; end
    test_reset();
    test_pass();
    test_fail_code();
    test_bypass();
    test_timeout();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_exit_monitor.md
Name: rv_exit_monitor

Overview:
- Synthesizable test-completion monitor for multi-hart RV32I simulation and FPGA builds.
- Snoops each hart's register-file writeback port and ecall strobe, and shadows a0 (x10) and a7 (x17).
- Reports pass/fail using the riscv-tests exit convention: ecall with a7=93 (0x5d); pass when a0=0, exit code = a0>>1.
- Adds per-run cycle and instret counters, a timeout watchdog, and a latched result. The bench stops on done_o.

Parameters:
NUM_HARTS, 1, number of snooped harts (1..8)
EXIT_ID, 32'h5d, a7 value marking the exit syscall
CNT_W, 32, width of cycle/instret counters
TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables
TOHOST_ADDR, 32'h0000_1000, tohost word address (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  pulse; IDLE->RUN
wb_en_i  in  NUM_HARTS  writeback valid per hart
wb_addr_i  in  5*NUM_HARTS  writeback rd; hart h at [5h+:5]
wb_data_i  in  32*NUM_HARTS  writeback data; hart h at [32h+:32]
ecall_i  in  NUM_HARTS  ecall retire strobe per hart
retire_i  in  NUM_HARTS  instruction retire strobe per hart
st_en_i  in  1  data store valid (optional feature only)
st_addr_i  in  32  store byte address (optional feature only)
st_data_i  in  32  store data (optional feature only)
done_o  out  1  result latched
pass_o  out  1  exit with code 0
fail_o  out  1  exit with nonzero code
timeout_o  out  1  watchdog expired
exit_code_o  out  32  a0>>1 (or tohost>>1) at exit
exit_hart_o  out  3  hart that exited
cycle_cnt_o  out  CNT_W  cycles spent in RUN
instret_cnt_o  out  CNT_W  total retirements, all harts

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE.
  - All outputs 0; shadows and counters 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: shadows still track writebacks; counters hold. start_i -> RUN, and counters clear that same edge.
  - RUN: each cycle, cycle_cnt += 1 and instret_cnt += popcount(retire_i). Both saturate at all-ones.
  - DONE: terminal. Outputs are stable until reset; start_i is ignored.
- Shadow update:
  - wb_en_i[h] with rd=10 or rd=17 writes the corresponding shadow on the next edge.
  - rd=0 and all other rd values are ignored.
- Exit detection (RUN only):
  - Triggers on ecall_i[h]=1 when effective a7 == EXIT_ID.
  - Effective a7/a0 = the same-cycle writeback value when wb_en_i[h] targets that register (bypass); otherwise the shadow value.
  - On exit, next edge: state DONE, done_o=1, exit_code_o = a0>>1, pass_o = (a0==0), fail_o = !pass_o, exit_hart_o = h.
- Simultaneous exits: the lowest hart index wins.
- Watchdog:
  - When TIMEOUT_CYCLES!=0 and cycle_cnt reaches TIMEOUT_CYCLES-1 in RUN, next edge: DONE, timeout_o=1, fail_o=1, exit_code_o=0.
  - Exit and timeout in the same cycle: exit wins and timeout_o stays 0.
- Counter snapshot: counters freeze on entry to DONE. The final cycle is counted; retirements in the exit cycle are counted.
- ecall_i with a7 != EXIT_ID: no effect.
- Reset mid-RUN returns to IDLE immediately and clears everything; a new start_i is required.
- Latency:
  - Exit strobe to done_o: 1 cycle.
  - writeback to shadow: 1 cycle; the bypass makes the exit effectively 0-latency.

Optional Feature:
- Macro RV_EXIT_MONITOR_TOHOST_EN.
- Defined: in RUN, st_en_i with st_addr_i==TOHOST_ADDR and st_data_i[0]=1 is treated as an exit.
  - exit_code_o = st_data_i>>1.
  - pass_o when st_data_i==1.
  - exit_hart_o = 0.
- Priority within one cycle: ecall exit beats tohost exit.
- Not defined: st_* ports are still present but ignored; the compare logic is not built.

Test Plan:
- Reset, start, hart0 wb x10=0, wb x17=0x5d, ecall one cycle later -> done_o=1, pass_o=1, exit_code_o=0, exit_hart_o=0 on the next edge.
- hart0 wb x10=0x6 then ecall with x17=0x5d -> fail_o=1, exit_code_o=3.
- wb x17=0x5d and ecall in the same cycle with shadow x17=0 -> exit taken via bypass, done_o next edge.
- TIMEOUT_CYCLES=100, no ecall -> timeout_o=1, fail_o=1, cycle_cnt_o=100. A further ecall in DONE does not change outputs.
- NUM_HARTS=2, both harts ecall-exit the same cycle (hart1 a0=0, hart0 a0=4) -> exit_hart_o=0, fail_o=1, exit_code_o=2.
- Assert rst_i mid-RUN after 37 cycles -> all outputs 0 immediately and state IDLE. With RV_EXIT_MONITOR_TOHOST_EN, store 0x1 to 0x1000 after restart -> pass_o=1.
